// File: rtl/ram_stream_reader.sv
// ram_stream_reader: walks a block of a combinational-read RAM and presents
// the words as a valid/ready stream. A burst is requested with start,
// base_addr and length while idle. The output beat register is reloaded
// whenever it is empty or being consumed, so a consumer that always accepts
// gets one word per cycle. done pulses for one cycle when the last beat has
// been taken.
module ram_stream_reader #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   REM_ZERO  = {(ADDR_WIDTH+1){1'b0}};
    localparam logic [ADDR_WIDTH:0]   REM_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    // Largest useful burst: every RAM word once.
    localparam logic [ADDR_WIDTH:0]   LEN_MAX   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    state_t                state_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [ADDR_WIDTH:0]   remaining_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic                  valid_r;
    logic                  last_r;
    logic                  busy_r;
    logic                  done_r;

    logic [ADDR_WIDTH:0]   len_clamped_s;
    logic                  load_s;

    // The RAM address comes straight from a register so the RAM read path
    // never sees combinational logic from the block's inputs.
    assign rd_addr = addr_r;
    assign m_data  = data_r;
    assign m_valid = valid_r;
    assign m_last  = last_r;
    assign busy    = busy_r;
    assign done    = done_r;

    // Clamp the requested length to the RAM size; anything with the top
    // bit set is at least 2**ADDR_WIDTH.
    always_comb begin
        len_clamped_s = length;
        if (length[ADDR_WIDTH]) begin
            len_clamped_s = LEN_MAX;
        end else begin
            len_clamped_s = length;
        end
    end

    // A new word is loaded when the beat register is empty or being drained
    // this cycle and words are still outstanding.
    always_comb begin
        load_s = 1'b0;
        if ((state_r == ST_READ) && (!valid_r || m_ready) && (remaining_r != REM_ZERO)) begin
            load_s = 1'b1;
        end else begin
            load_s = 1'b0;
        end
    end

    // Burst sequencer together with the registered stream outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            addr_r      <= ADDR_ZERO;
            remaining_r <= REM_ZERO;
            data_r      <= DATA_ZERO;
            valid_r     <= 1'b0;
            last_r      <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        if (length == REM_ZERO) begin
                            // Empty burst: report completion, produce nothing.
                            done_r <= 1'b1;
                        end else begin
                            addr_r      <= base_addr;
                            remaining_r <= len_clamped_s;
                            busy_r      <= 1'b1;
                            state_r     <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (load_s) begin
                        data_r      <= rd_data;
                        valid_r     <= 1'b1;
                        last_r      <= (remaining_r == REM_ONE);
                        addr_r      <= addr_r + ADDR_ONE;
                        remaining_r <= remaining_r - REM_ONE;
                        if (remaining_r == REM_ONE) begin
                            state_r <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Only the final beat is pending; finish when it is taken.
                    if (valid_r && m_ready) begin
                        valid_r <= 1'b0;
                        last_r  <= 1'b0;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    last_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ram_stream_reader.md
RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, as the address width of the attached RAM.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, as the word width of the attached RAM.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, a request to begin a burst, sampled only in IDLE.
REQ-006 SHALL have port base_addr, input, ADDR_WIDTH, the first RAM word of the burst, captured with start.
REQ-007 SHALL have port length, input, ADDR_WIDTH+1, the word count of the burst, captured with start.
REQ-008 SHALL have port rd_addr, output, ADDR_WIDTH, driving one combinational read port of the RAM.
REQ-009 SHALL have port rd_data, input, DATA_WIDTH, the word returned by the RAM in the same cycle as rd_addr.
REQ-010 SHALL have port m_data, output, DATA_WIDTH, the stream data.
REQ-011 SHALL have port m_valid, output, 1, indicating that m_data and m_last hold a beat.
REQ-012 SHALL have port m_last, output, 1, marking the final beat of the burst.
REQ-013 SHALL have port m_ready, input, 1, the consumer's acceptance signal; a beat transfers on an edge where m_valid=1 and m_ready=1.
REQ-014 SHALL have port busy, output, 1, high while the state is not IDLE.
REQ-015 SHALL have port done, output, 1, a one-cycle pulse at burst completion.

Function
REQ-016 SHALL implement the states IDLE, READ and DRAIN.
REQ-017 IDLE, start=1, length!=0: capture base_addr into the address register and the clamped length into the remaining counter, then go to READ.
REQ-018 IDLE, start=1, length=0: stay in IDLE and pulse done on the next cycle; no beats are produced.
REQ-019 A length greater than 2**ADDR_WIDTH SHALL be clamped to 2**ADDR_WIDTH.
REQ-020 rd_addr SHALL be driven directly from the address register, with no combinational path from the inputs.
REQ-021 A load event occurs in READ on any edge where (m_valid=0 or m_ready=1) and remaining!=0.
REQ-022 On a load event: m_data<=rd_data, m_valid<=1, m_last<=(remaining==1), address increments, and remaining decrements.
REQ-023 The address SHALL increment modulo 2**ADDR_WIDTH, so a burst wraps from the top address to address 0.
REQ-024 READ goes to DRAIN on the load event where remaining reaches 0.
REQ-025 In DRAIN, on the handshake edge of the last beat: m_valid<=0, m_last<=0, done pulses high for the next cycle, and the state returns to IDLE.
REQ-026 With m_ready held at 1, throughput SHALL be one beat per cycle with no bubbles.
REQ-027 Latency: start sampled at edge N gives m_valid=1 after edge N+1, with m_data=RAM[base_addr].
REQ-028 While m_valid=1 and m_ready=0, m_data, m_last and rd_addr SHALL hold stable.
REQ-029 start SHALL be ignored while busy=1.
REQ-030 busy SHALL be 0 in the cycle done=1, so a new start is accepted in that cycle.
REQ-031 Each beat SHALL carry the RAM contents sampled at its load edge; a RAM write to a not-yet-loaded address before its load edge is reflected in the stream.
REQ-032 A 2**ADDR_WIDTH-word burst SHALL read every address exactly once.

Reset
REQ-033 When reset=1 at an edge, the state goes to IDLE and m_valid, m_last, busy, done, m_data, rd_addr and remaining all become 0.
REQ-034 Reset SHALL take priority over start and over any handshake in the same cycle.
REQ-035 Reset mid-burst SHALL abort the burst with no done pulse; the next start begins a fresh burst.

Verification
REQ-036 Basic burst: RAM[0x010..0x013]=A0..A3, base=0x010, len=4, m_ready=1 -> beats A0,A1,A2,A3 on 4 consecutive cycles; m_last only on A3; done one cycle after the A3 handshake.
REQ-037 Backpressure: same burst with m_ready toggling 1,0,0,1,... -> data and m_last held stable while stalled, no beat lost or duplicated, order A0..A3.
REQ-038 Wrap-around: ADDR_WIDTH=12, base=0xFFE, len=4 -> rd_addr sequence 0xFFE, 0xFFF, 0x000, 0x001; beats match RAM at those addresses.
REQ-039 Zero/clamp: len=0 -> done pulse with no m_valid; len=0x1FFF -> exactly 4096 beats, then done.
REQ-040 Reset mid-burst: reset after the 2nd beat of a len=8 burst -> all outputs 0, no done; a new start with base=0x100, len=1 gives a single beat RAM[0x100] with m_last=1.
REQ-041 Start while busy: a start pulse during a burst -> ignored; beat count equals the original length.
